// File: rtl/lite16_pkg.sv
// Shared definitions for the LITE-16 sequencer: opcodes, FSM state
// encoding, write-back select codes and the handshake timeout counter width.
package lite16_pkg;

  localparam logic [3:0] OP_ALUI = 4'hA;
  localparam logic [3:0] OP_LD   = 4'hB;
  localparam logic [3:0] OP_ST   = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_JAL  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int TMO_W = 8;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT,
    ST_FAULT
  } state_t;

  typedef enum logic [1:0] {
    WB_ALU,
    WB_LOAD,
    WB_LINK
  } wb_sel_t;

  typedef struct packed {
    logic    ri;
    logic    jmp;
    logic    fn;
    logic    writes;
    logic    is_mem;
    logic    is_store;
    logic    is_halt;
    wb_sel_t wb_sel;
  } ctrl_t;

  function automatic logic [15:0] pc_inc(input logic [15:0] p);
    return p + 16'd1;
  endfunction

endpackage

// File: rtl/lite16_if.sv
// Instruction and data memory request/acknowledge bus of the LITE-16 core.
interface lite16_if;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_ack;
  logic [15:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/lite16_decoder.sv
// Combinational opcode decoder: maps IR[3:0] to register fetch unit
// controls and the sequencing attributes the FSM needs.
module lite16_decoder
  import lite16_pkg::*;
(
  input  logic [3:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl.ri       = 1'b0;
    ctrl.jmp      = 1'b0;
    ctrl.fn       = 1'b0;
    ctrl.writes   = 1'b0;
    ctrl.is_mem   = 1'b0;
    ctrl.is_store = 1'b0;
    ctrl.is_halt  = 1'b0;
    ctrl.wb_sel   = WB_ALU;
    case (opcode)
      OP_ALUI: begin
        ctrl.ri     = 1'b1;
        ctrl.writes = 1'b1;
      end
      OP_LD: begin
        ctrl.fn     = 1'b1;
        ctrl.writes = 1'b1;
        ctrl.is_mem = 1'b1;
        ctrl.wb_sel = WB_LOAD;
      end
      OP_ST: begin
        ctrl.is_mem   = 1'b1;
        ctrl.is_store = 1'b1;
      end
      OP_JMP: ctrl.jmp = 1'b1;
      OP_JAL: begin
        ctrl.jmp    = 1'b1;
        ctrl.fn     = 1'b1;
        ctrl.writes = 1'b1;
        ctrl.wb_sel = WB_LINK;
      end
      OP_HALT: ctrl.is_halt = 1'b1;
      // 0x0-0x9 are register-register ALU operations
      default: ctrl.writes = 1'b1;
    endcase
  end

endmodule

// File: rtl/lite16_sequencer.sv
// LITE-16 multi-cycle control FSM: instruction fetch, decode, optional data
// memory access and write-back, with a handshake timeout that traps to FAULT.
module lite16_sequencer
  import lite16_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  lite16_if.master    bus,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] alu_y,
  output logic [3:0]  i4_7,
  output logic [3:0]  i8_11,
  output logic [3:0]  i12_15,
  output logic        ri,
  output logic        st,
  output logic        jmp,
  output logic        fn,
  output logic [15:0] r,
  output logic [15:0] pc,
  output logic        halted,
  output logic        fault
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t             state_reg, state_next;
  logic [15:0]        ir_reg;
  logic [15:0]        pc_reg;
  logic [15:0]        load_reg;
  logic               imem_req_reg;
  logic               dmem_req_reg;
  logic [TMO_W-1:0]   wait_cnt_reg, wait_cnt_next;
  ctrl_t              ctrl;
  logic               fetch_wait, mem_wait, fetch_done, mem_done, timed_out;

  lite16_decoder u_decoder (
    .opcode (ir_reg[3:0]),
    .ctrl   (ctrl)
  );

  // An ack only counts while our own request is actually on the bus.
  assign fetch_wait = (state_reg == ST_FETCH) && imem_req_reg;
  assign mem_wait   = (state_reg == ST_MEM) && dmem_req_reg;
  assign fetch_done = fetch_wait && bus.imem_ack;
  assign mem_done   = mem_wait && bus.dmem_ack;
  assign timed_out  = ((fetch_wait && !bus.imem_ack) || (mem_wait && !bus.dmem_ack))
                      && (wait_cnt_reg == TMO_LAST);

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = (fetch_wait || mem_wait) ? wait_cnt_reg + TMO_W'(1) : '0;
    st            = 1'b1;
    r             = '0;
    case (state_reg)
      ST_FETCH: begin
        if (fetch_done)     state_next = ST_DECODE;
        else if (timed_out) state_next = ST_FAULT;
      end
      ST_DECODE: state_next = ctrl.is_halt ? ST_HALT : ST_EXEC;
      ST_EXEC:   state_next = ctrl.is_mem ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (mem_done)       state_next = ST_WB;
        else if (timed_out) state_next = ST_FAULT;
      end
      ST_WB: begin
        state_next = ST_FETCH;
        st         = ~ctrl.writes;
        case (ctrl.wb_sel)
          WB_LOAD: r = load_reg;
          WB_LINK: r = pc_inc(pc_reg);
          default: r = alu_y;
        endcase
      end
      ST_HALT, ST_FAULT: state_next = state_reg;
      default: state_next = ST_FAULT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_FETCH;
      pc_reg       <= RESET_PC;
      ir_reg       <= '0;
      load_reg     <= '0;
      imem_req_reg <= 1'b0;
      dmem_req_reg <= 1'b0;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      imem_req_reg <= (state_next == ST_FETCH);
      dmem_req_reg <= (state_next == ST_MEM);
      if (fetch_done) ir_reg <= bus.imem_rdata;
      if (mem_done && !ctrl.is_store) load_reg <= bus.dmem_rdata;
      if (state_reg == ST_WB) pc_reg <= ctrl.jmp ? a : pc_inc(pc_reg);
    end
  end

  assign bus.imem_req   = imem_req_reg;
  assign bus.imem_addr  = pc_reg;
  assign bus.dmem_req   = dmem_req_reg;
  assign bus.dmem_we    = dmem_req_reg && ctrl.is_store;
  assign bus.dmem_addr  = a;
  assign bus.dmem_wdata = b;

  assign i4_7   = ir_reg[7:4];
  assign i8_11  = ir_reg[11:8];
  assign i12_15 = ir_reg[15:12];
  assign ri     = ctrl.ri;
  assign jmp    = ctrl.jmp;
  assign fn     = ctrl.fn;
  assign pc     = pc_reg;
  assign halted = (state_reg == ST_HALT);
  assign fault  = (state_reg == ST_FAULT);

endmodule

// File: tb/tb_lite16_sequencer.sv
// Scoreboard bench for lite16_sequencer: the driver plays both memories and
// queues expected fetch addresses, data requests and register writes.
module tb_lite16_sequencer;

  localparam int          TMO = 12;
  localparam logic [15:0] RPC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] a = '0, b = '0, alu_y = '0;
  logic [3:0]  i4_7, i8_11, i12_15;
  logic        ri, st, jmp, fn, halted, fault;
  logic [15:0] r, pc;

  always #5 clk = ~clk;

  lite16_if bus();

  lite16_sequencer #(.RESET_PC(RPC), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .bus(bus), .a(a), .b(b), .alu_y(alu_y),
    .i4_7(i4_7), .i8_11(i8_11), .i12_15(i12_15),
    .ri(ri), .st(st), .jmp(jmp), .fn(fn),
    .r(r), .pc(pc), .halted(halted), .fault(fault)
  );

  typedef struct { logic [15:0] instr; logic [15:0] val; } wr_t;
  typedef struct { logic we; logic [15:0] addr; logic [15:0] wdata; } dm_t;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] pc_q[$];
  wr_t         wr_q[$];
  dm_t         dm_q[$];
  logic [15:0] pc_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Monitor: pops the expected response whenever the DUT presents one
  logic prev_ireq = 1'b0, prev_dreq = 1'b0;
  wr_t  mw;
  dm_t  md;
  logic [3:0] mop;
  always @(negedge clk) begin
    if (rst) begin
      prev_ireq = 1'b0;
      prev_dreq = 1'b0;
    end else begin
      if (bus.imem_req && !prev_ireq) begin
        if (pc_q.size() == 0) fail_evt("fetch_addr", "got unexpected fetch, expected none");
        else check("fetch_addr", 32'(bus.imem_addr), 32'(pc_q.pop_front()));
      end
      if (bus.dmem_req && !prev_dreq) begin
        if (dm_q.size() == 0) fail_evt("dmem_req", "got unexpected data request, expected none");
        else begin
          md = dm_q.pop_front();
          check("dmem_we", 32'(bus.dmem_we), 32'(md.we));
          check("dmem_addr", 32'(bus.dmem_addr), 32'(md.addr));
          if (md.we) check("dmem_wdata", 32'(bus.dmem_wdata), 32'(md.wdata));
        end
      end
      if (!st) begin
        if (wr_q.size() == 0) fail_evt("reg_write", "got st low, expected st high");
        else begin
          mw  = wr_q.pop_front();
          mop = mw.instr[3:0];
          check("wb_fields", 32'({i12_15, i8_11, i4_7}), 32'(mw.instr[15:4]));
          check("wb_r", 32'(r), 32'(mw.val));
          check("wb_ctrl", 32'({ri, jmp, fn}),
                32'({mop == 4'hA, mop == 4'hD || mop == 4'hE, mop == 4'hB || mop == 4'hE}));
        end
      end
      prev_ireq = bus.imem_req;
      prev_dreq = bus.dmem_req;
    end
  end

  task automatic apply_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    pc_q.delete();
    wr_q.delete();
    dm_q.delete();
    #1;
    check("rst_imem_req", 32'(bus.imem_req), 32'(0));
    check("rst_dmem_req", 32'({bus.dmem_req, bus.dmem_we}), 32'(0));
    check("rst_pc", 32'(pc), 32'(RPC));
    check("rst_ctrl", 32'({st, ri, jmp, fn, halted, fault}), 32'(6'b100000));
    check("rst_r_ir", 32'({r, i12_15, i8_11, i4_7}), 32'(0));
    repeat (2) @(negedge clk);
    pc_m = RPC;
    pc_q.push_back(RPC);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Reference model: architectural effect of one instruction, then drive it
  task automatic run_instr(input logic [15:0] instr, input logic [15:0] av, input logic [15:0] bv,
                           input logic [15:0] yv, input logic [15:0] rd,
                           input int iw, input int dw, input bit abort_mem);
    logic [3:0]  op;
    logic [15:0] npc;
    int          k;
    int          held;
    op = instr[3:0];
    k = 0;
    while (!bus.imem_req && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!bus.imem_req) begin
      fail_evt("imem_req", "got no fetch request, expected one");
      return;
    end
    npc = (op == 4'hD || op == 4'hE) ? av : pc_m + 16'd1;
    if (op != 4'hF) pc_q.push_back(npc);
    if (op == 4'hB || op == 4'hC) dm_q.push_back('{we: (op == 4'hC), addr: av, wdata: bv});
    if (op <= 4'hA)      wr_q.push_back('{instr: instr, val: yv});
    else if (op == 4'hB) wr_q.push_back('{instr: instr, val: rd});
    else if (op == 4'hE) wr_q.push_back('{instr: instr, val: pc_m + 16'd1});

    repeat (iw) @(negedge clk);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = instr;
    a = av;
    b = bv;
    alu_y = yv;
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 16'($urandom);
    k = 1;
    if (op == 4'hF) begin
      while (!halted && k < 10) begin
        @(negedge clk);
        k++;
      end
      check("halt_latency", 32'(k), 32'(2));
    end else if (op == 4'hB || op == 4'hC) begin
      while (!bus.dmem_req && k < 10) begin
        @(negedge clk);
        k++;
      end
      check("mem_req_latency", 32'(k), 32'(3));
      if (abort_mem) return;
      held = 0;
      for (int i = 0; i <= dw; i++) begin
        if (bus.dmem_req) held++;
        if (i < dw) @(negedge clk);
      end
      check("dmem_req_held", 32'(held), 32'(dw + 1));
      bus.dmem_ack   = 1'b1;
      bus.dmem_rdata = rd;
      @(negedge clk);
      bus.dmem_ack   = 1'b0;
      bus.dmem_rdata = 16'($urandom);
      k = 1;
      while (!bus.imem_req && k < 10) begin
        @(negedge clk);
        k++;
      end
      check("mem_to_fetch_latency", 32'(k), 32'(2));
    end else begin
      while (!bus.imem_req && k < 10) begin
        @(negedge clk);
        k++;
      end
      check("fetch_latency", 32'(k), 32'(4));
    end
    if (op != 4'hF) pc_m = npc;
  endtask

  initial begin
    int n;
    logic [15:0] ri_instr;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = '0;

    apply_reset();
    run_instr(16'h3210, 16'h0000, 16'h0000, 16'h00AA, 16'h0000, 0, 0, 0);
    run_instr(16'h042B, 16'h1234, 16'h0000, 16'h7777, 16'hBEEF, 0, 3, 0);
    run_instr(16'h000C, 16'h0010, 16'h5555, 16'h1111, 16'h0000, 1, 0, 0);
    run_instr(16'h000D, 16'hFFFF, 16'h0000, 16'h2222, 16'h0000, 0, 0, 0);
    run_instr(16'h070E, 16'h0100, 16'h0000, 16'h3333, 16'h0000, 2, 0, 0);
    run_instr(16'h5A6A, 16'h0000, 16'h0000, 16'hC0DE, 16'h0000, 0, 0, 0);
    run_instr(16'h1239, 16'h0000, 16'h0000, 16'h4444, 16'h0000, TMO - 1, 0, 0);

    for (int i = 0; i < 40; i++) begin
      ri_instr = {16'($urandom) & 16'hFFF0} | 16'($urandom_range(0, 14));
      run_instr(ri_instr, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end
    @(negedge clk);
    check("pc_q_drained", 32'(pc_q.size()), 32'(0));
    check("wr_q_drained", 32'(wr_q.size()), 32'(0));
    check("dm_q_drained", 32'(dm_q.size()), 32'(0));

    // HALT: acks with no request must be ignored and everything frozen
    run_instr(16'h000F, 16'h0ABC, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      bus.imem_ack = 1'b1;
      bus.dmem_ack = 1'b1;
      @(negedge clk);
      check("halt_quiet", 32'({bus.imem_req, bus.dmem_req, halted, st, fault}), 32'(5'b00110));
      check("halt_pc", 32'(pc), 32'(pc_m));
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;

    // Reset while a load is waiting on dmem_ack; a late ack must be ignored
    apply_reset();
    run_instr(16'h5ABB, 16'h2000, 16'h0000, 16'h0000, 16'h1357, 0, 0, 1);
    apply_reset();
    @(negedge clk);
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 16'hDEAD;
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    check("late_ack_dmem_req", 32'(bus.dmem_req), 32'(0));
    run_instr(16'h0121, 16'h0000, 16'h0000, 16'h9999, 16'h0000, 0, 0, 0);

    // Withheld fetch ack: request stays up exactly TMO cycles, then FAULT
    apply_reset();
    n = 0;
    while (!bus.imem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (bus.imem_req && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("timeout_req_cycles", 32'(n), 32'(TMO));
    check("timeout_fault", 32'({fault, bus.imem_req, halted}), 32'(3'b100));

    apply_reset();
    repeat (3) @(negedge clk);
    check("final_pc_q_drained", 32'(pc_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lite16_sequencer.md
Name: lite16_sequencer

Overview:
Multi-cycle control FSM for the LITE-16 core. Fetches 16-bit instructions over a req/ack instruction port, holds them in an instruction register and drives the register fetch unit's field and control inputs (i4_7, i8_11, i12_15, ri, st, jmp, fn). Sequences data-memory access and the PC, and selects write-back data onto r. Register writes are gated by holding st high outside the WRITEBACK state.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
TIMEOUT, 255, max cycles waiting for any ack before entering FAULT (8-bit counter; legal range 1..255)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
imem_req  out  1  instruction fetch request
imem_addr  out  16  fetch address (= pc)
imem_ack  in  1  single-cycle fetch acknowledge
imem_rdata  in  16  instruction word, valid with imem_ack
dmem_req  out  1  data request
dmem_we  out  1  1 = store, 0 = load
dmem_addr  out  16  data address (= a)
dmem_wdata  out  16  store data (= b)
dmem_ack  in  1  single-cycle data acknowledge
dmem_rdata  in  16  load data, valid with dmem_ack
a  in  16  register fetch unit output A
b  in  16  register fetch unit output B
alu_y  in  16  ALU result
i4_7, i8_11, i12_15  out  4 each  IR[7:4], IR[11:8], IR[15:12]
ri, st, jmp, fn  out  1 each  register fetch unit controls
r  out  16  write-back data
pc  out  16  program counter
halted  out  1  HALT executed
fault  out  1  handshake timeout

Behaviour:
- Reset (async): pc=RESET_PC; imem_req=dmem_req=dmem_we=0; IR=0; ri=jmp=fn=0; st=1; r=0; halted=fault=0; state=FETCH; timeout counter=0. Reset mid-handshake drops req immediately; any later ack is ignored.
- Opcode = IR[3:0]. 0x0-0x9 ALU: ri=0 fn=0, writes i12_15 <= alu_y. 0xA ALUI: ri=1 fn=0, writes i12_15 <= alu_y. 0xB LD: fn=1, writes i8_11 <= dmem_rdata. 0xC ST: st=1 throughout. 0xD JMP: jmp=1 fn=0, no write, pc <= a. 0xE JAL: jmp=1 fn=1, writes i8_11 <= pc+1, pc <= a. 0xF HALT.
- ri/jmp/fn are decoded from IR and stable from DECODE through WRITEBACK; st=1 in every state except WRITEBACK of writing opcodes (ALU, ALUI, LD, JAL).
- States: FETCH -> DECODE -> EXEC -> [MEM] -> WRITEBACK -> FETCH; HALT and FAULT terminal until rst.
- FETCH: imem_req=1, imem_addr=pc held stable. On imem_ack: IR <= imem_rdata, req drops in the same edge, -> DECODE.
- DECODE: 1 cycle, fields settle. HALT opcode -> HALT (halted=1, pc unchanged).
- EXEC: 1 cycle. LD/ST -> MEM; all other opcodes -> WRITEBACK.
- MEM: dmem_req=1, dmem_we=(ST), addr=a, wdata=b held until dmem_ack. LD latches dmem_rdata into a load register on ack. -> WRITEBACK.
- WRITEBACK: 1 cycle; r = mux(alu_y | load reg | pc+1) per opcode; pc <= a for JMP/JAL, else pc+1 (16-bit wrap, 16'hFFFF -> 16'h0000).
- Latency (zero-wait ack): ALU/JMP 4 cycles, LD/ST 5 cycles.
- Ack outside the matching request state is ignored. Ack in the first request cycle is accepted.
- Timeout: counter clears on entering FETCH/MEM and increments each waiting cycle. If TIMEOUT cycles pass without ack: req drops, fault=1 -> FAULT. Ack on the TIMEOUT-th cycle is accepted (ack wins).
- In HALT/FAULT: st=1, no requests, outputs frozen.

Decomposition:
- Package lite16_pkg: opcode constants, state enum encoding, write-back select codes, TIMEOUT width.
- Sub-module lite16_decoder: combinational opcode -> {ri, jmp, fn, writes, is_mem, is_store, wb_sel}. FSM, PC and counters stay in lite16_sequencer.

Test Plan:
- Reset release, imem_rdata=16'h3210 (ALU op 0), alu_y=16'h00AA -> imem_addr=0000; st low exactly 1 cycle at WRITEBACK with r=00AA, i12_15=3; pc=0001 at 4 cycles after ack.
- LD 16'h042B, a=16'h1234, dmem_ack after 3 wait cycles with rdata=BEEF -> dmem_addr=1234, dmem_we=0, req held 4 cycles; WRITEBACK r=BEEF, fn=1, i8_11=4.
- ST 16'h000C, a=0010, b=5555 -> dmem_we=1, wdata=5555; st never low; pc increments.
- JAL at pc=FFFF, a=0100 -> r=0000 (wrapped link), pc=0100; JMP -> st never low, pc=a.
- HALT, then ack pulses with no request -> halted=1, no requests, pc frozen. Withheld imem_ack for TIMEOUT cycles -> fault=1, imem_req=0.
- rst asserted while dmem_req=1 -> dmem_req=0 immediately, pc=RESET_PC; a late dmem_ack is ignored.
